// File: rtl/rpn_eval_if.sv
// Character-stream handshake between an RPN source/sink and rpn_eval.
// The master side drives characters in and acknowledges results; the slave is the evaluator.
interface rpn_eval_if;
  logic       in_stb;
  logic [7:0] in_char;
  logic       in_ack;
  logic       out_stb;
  logic [7:0] out_char;
  logic       out_ack;
  logic       err;

  modport master (output in_stb, in_char, out_ack,
                  input  in_ack, out_stb, out_char, err);
  modport slave  (input  in_stb, in_char, out_ack,
                  output in_ack, out_stb, out_char, err);
endinterface

// File: rtl/rpn_eval.sv
// Postfix evaluator: single-digit operands, 8x16 signed stack, decimal result stream.
// Define RPN_EVAL_DIV_EN to build the 16-cycle restoring divider for '/'.
module rpn_eval (
  input  logic       clk_i,
  input  logic       rst_i,
  rpn_eval_if.slave  bus
);
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
`ifdef RPN_EVAL_DIV_EN
    S_DIV  = 3'd2,
`endif
    S_CONV = 3'd3,
    S_EMIT = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [3:0]                sp_q, sp_d;
  logic                      experr_q, experr_d;
  logic                      err_q, err_d;
  logic                      in_ack_q, in_ack_d;
  logic [7:0]                ch_q, ch_d;
  logic signed [DATA_W-1:0]  stk_q [8];
  logic                      stk_we;
  logic [2:0]                stk_wa;
  logic signed [DATA_W-1:0]  stk_wd;
  logic [DATA_W-1:0]         mag_q, mag_d;
  logic [2:0]                pidx_q, pidx_d;
  logic [3:0]                dig_q, dig_d;
  logic                      lead_q, lead_d;
  logic [7:0]                obuf_q [8];
  logic [7:0]                obuf_d [8];
  logic [2:0]                olen_q, olen_d;
  logic [2:0]                opos_q, opos_d;
`ifdef RPN_EVAL_DIV_EN
  logic [DATA_W-1:0]         dvd_q, dvd_d;
  logic [DATA_W-1:0]         den_q, den_d;
  logic [DATA_W-1:0]         rem_q, rem_d;
  logic                      dneg_q, dneg_d;
  logic [3:0]                dcnt_q, dcnt_d;
  logic [DATA_W:0]           div_rs;
  logic                      div_qbit;
  logic [DATA_W-1:0]         div_qnext;
`endif

  logic [2:0]               ia, ib;
  logic signed [DATA_W-1:0] opa, opb;

  assign ia  = 3'(sp_q - 4'd2);
  assign ib  = 3'(sp_q - 4'd1);
  assign opa = stk_q[ia];
  assign opb = stk_q[ib];

  function automatic logic signed [DATA_W-1:0] alu(input logic [7:0] op,
                                                   input logic signed [DATA_W-1:0] x,
                                                   input logic signed [DATA_W-1:0] y);
    case (op)
      8'h2B:   alu = x + y;
      8'h2D:   alu = x - y;
      default: alu = x * y;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] pow10(input logic [2:0] i);
    case (i)
      3'd0:    pow10 = 16'd10000;
      3'd1:    pow10 = 16'd1000;
      3'd2:    pow10 = 16'd100;
      3'd3:    pow10 = 16'd10;
      default: pow10 = 16'd1;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      sp_q     <= 4'd0;
      experr_q <= 1'b0;
      err_q    <= 1'b0;
      in_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      experr_q <= experr_d;
      err_q    <= err_d;
      in_ack_q <= in_ack_d;
    end
  end

  always_ff @(posedge clk_i) begin
    ch_q   <= ch_d;
    mag_q  <= mag_d;
    pidx_q <= pidx_d;
    dig_q  <= dig_d;
    lead_q <= lead_d;
    obuf_q <= obuf_d;
    olen_q <= olen_d;
    opos_q <= opos_d;
    if (stk_we) stk_q[stk_wa] <= stk_wd;
`ifdef RPN_EVAL_DIV_EN
    dvd_q  <= dvd_d;
    den_q  <= den_d;
    rem_q  <= rem_d;
    dneg_q <= dneg_d;
    dcnt_q <= dcnt_d;
`endif
  end

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    experr_d = experr_q;
    err_d    = err_q;
    in_ack_d = 1'b0;
    ch_d     = ch_q;
    mag_d    = mag_q;
    pidx_d   = pidx_q;
    dig_d    = dig_q;
    lead_d   = lead_q;
    obuf_d   = obuf_q;
    olen_d   = olen_q;
    opos_d   = opos_q;
    stk_we   = 1'b0;
    stk_wa   = ib;
    stk_wd   = '0;
`ifdef RPN_EVAL_DIV_EN
    dvd_d     = dvd_q;
    den_d     = den_q;
    rem_d     = rem_q;
    dneg_d    = dneg_q;
    dcnt_d    = dcnt_q;
    div_rs    = {rem_q, dvd_q[DATA_W-1]};
    div_qbit  = (div_rs >= {1'b0, den_q});
    div_qnext = {dvd_q[DATA_W-2:0], div_qbit};
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_stb && !in_ack_q) begin
          in_ack_d = 1'b1;
          ch_d     = bus.in_char;
          err_d    = 1'b0;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        if (ch_q >= 8'h30 && ch_q <= 8'h39) begin
          if (sp_q == 4'd8) experr_d = 1'b1;
          else begin
            stk_we = 1'b1;
            stk_wa = sp_q[2:0];
            stk_wd = {8'h00, ch_q - 8'h30};
            sp_d   = sp_q + 4'd1;
          end
        end else begin
          case (ch_q)
            8'h20: ;
            8'h2B, 8'h2D, 8'h2A: begin
              if (sp_q < 4'd2) experr_d = 1'b1;
              else begin
                stk_we = 1'b1;
                stk_wa = ia;
                stk_wd = alu(ch_q, opa, opb);
                sp_d   = sp_q - 4'd1;
              end
            end
            8'h2F: begin
`ifdef RPN_EVAL_DIV_EN
              if (sp_q < 4'd2 || opb == 16'sd0) experr_d = 1'b1;
              else begin
                // Divide magnitudes, re-apply the sign at the end: truncates toward zero.
                sp_d    = sp_q - 4'd1;
                dvd_d   = opa[DATA_W-1] ? 16'(-opa) : 16'(opa);
                den_d   = opb[DATA_W-1] ? 16'(-opb) : 16'(opb);
                rem_d   = '0;
                dneg_d  = opa[DATA_W-1] ^ opb[DATA_W-1];
                dcnt_d  = 4'd0;
                state_d = S_DIV;
              end
`else
              experr_d = 1'b1;
`endif
            end
            8'h3D: begin
              opos_d = 3'd0;
              if (experr_q || sp_q != 4'd1) begin
                obuf_d[0] = 8'h45;
                obuf_d[1] = 8'h0A;
                olen_d    = 3'd2;
                err_d     = 1'b1;
                state_d   = S_EMIT;
              end else begin
                // Negating -32768 yields 0x8000, which reads correctly as unsigned 32768.
                mag_d     = stk_q[0][DATA_W-1] ? 16'(-stk_q[0]) : 16'(stk_q[0]);
                obuf_d[0] = 8'h2D;
                olen_d    = stk_q[0][DATA_W-1] ? 3'd1 : 3'd0;
                pidx_d    = 3'd0;
                dig_d     = 4'd0;
                lead_d    = 1'b0;
                state_d   = S_CONV;
              end
            end
            default: experr_d = 1'b1;
          endcase
        end
      end
`ifdef RPN_EVAL_DIV_EN
      S_DIV: begin
        dvd_d  = div_qnext;
        rem_d  = div_qbit ? 16'(div_rs - {1'b0, den_q}) : div_rs[DATA_W-1:0];
        dcnt_d = dcnt_q + 4'd1;
        if (dcnt_q == 4'd15) begin
          stk_we  = 1'b1;
          stk_wa  = ib;
          stk_wd  = dneg_q ? 16'(-div_qnext) : div_qnext;
          state_d = S_IDLE;
        end
      end
`endif
      S_CONV: begin
        if (mag_q >= pow10(pidx_q)) begin
          mag_d = mag_q - pow10(pidx_q);
          dig_d = dig_q + 4'd1;
        end else begin
          dig_d  = 4'd0;
          pidx_d = pidx_q + 3'd1;
          if (pidx_q == 3'd4) begin
            obuf_d[olen_q]              = 8'h30 + {4'h0, dig_q};
            obuf_d[3'(olen_q + 3'd1)]   = 8'h0A;
            olen_d                      = olen_q + 3'd2;
            opos_d                      = 3'd0;
            state_d                     = S_EMIT;
          end else if (dig_q != 4'd0 || lead_q) begin
            obuf_d[olen_q] = 8'h30 + {4'h0, dig_q};
            olen_d         = olen_q + 3'd1;
            lead_d         = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (bus.out_ack) begin
          if (opos_q == 3'(olen_q - 3'd1)) begin
            sp_d     = 4'd0;
            experr_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            opos_d = opos_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ack   = in_ack_q;
    bus.err      = err_q;
    bus.out_stb  = (state_q == S_EMIT);
    bus.out_char = (state_q == S_EMIT) ? obuf_q[opos_q] : 8'h00;
  end
endmodule

// File: tb/tb_rpn_eval.sv
// Directed bench for rpn_eval: feeds RPN strings, checks the emitted text, ERR, stalls and reset.
// Honours RPN_EVAL_DIV_EN the same way as the design.
module tb_rpn_eval;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  rpn_eval_if bus ();

  rpn_eval dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input byte c);
    int n = 0;
    bus.in_char = c;
    bus.in_stb  = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.in_ack && n < 60);
    if (!bus.in_ack) chk("in_ack_wait", {31'd0, bus.in_ack}, 32'd1);
    bus.in_stb = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!bus.out_stb && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_stb) chk("out_stb_wait", {31'd0, bus.out_stb}, 32'd1);
  endtask

  task automatic get_char(output logic [7:0] c);
    wait_out();
    c = bus.out_char;
    bus.out_ack = 1'b1;
    @(posedge clk); #1;
    bus.out_ack = 1'b0;
  endtask

  task automatic expect_str(input string tag, input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      get_char(c);
      chk($sformatf("%s[%0d]", tag, i), c, s[i]);
    end
    get_char(c);
    chk({tag, "_lf"}, c, 8'h0A);
    chk({tag, "_stb_drop"}, bus.out_stb, 0);
  endtask

  task automatic run(input string tag, input string expr, input string res);
    send_str(expr);
    expect_str(tag, res);
  endtask

  initial begin
    logic [7:0] c;
    bus.in_stb  = 1'b0;
    bus.in_char = 8'h00;
    bus.out_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_stb", bus.out_stb, 0);
    chk("rst_out_char", bus.out_char, 0);
    chk("rst_in_ack", bus.in_ack, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;

    run("add", "34+=", "7");
    chk("add_err", bus.err, 0);
    run("sub_mul", "23-5*=", "-5");
    run("wrap", "99*9*9*9*=", "-6487");
    run("spaces", "12 3+ +=", "6");
    run("zero", "0=", "0");
    run("neg1", "89-=", "-1");
    run("min", "88*8*8*8*=", "-32768");
`ifdef RPN_EVAL_DIV_EN
    run("div", "73/=", "2");
    run("div_neg", "9 02-/=", "-4");
    run("div_min", "88*8*8*8*01-/=", "-32768");
    run("div0", "80/=", "E");
    chk("div0_err", bus.err, 1);
`else
    run("nodiv", "73/=", "E");
    chk("nodiv_err", bus.err, 1);
`endif
    run("under", "3+=", "E");
    chk("under_err", bus.err, 1);
    send("5");
    chk("err_drop", bus.err, 0);
    send("=");
    expect_str("recover", "5");

    run("ovf", "123456789=", "E");
    chk("ovf_err", bus.err, 1);

    // Sink stalls for 10 cycles with a character pending at the input.
    send_str("99*9*9*=");
    wait_out();
    bus.in_char = 8'h31;
    bus.in_stb  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_stb%0d", i), bus.out_stb, 1);
      chk($sformatf("stall_char%0d", i), bus.out_char, 8'h36);
      chk($sformatf("stall_in_ack%0d", i), bus.in_ack, 0);
    end
    bus.in_stb = 1'b0;
    expect_str("stall", "6561");

    // Reset in the middle of a result abandons the rest.
    send_str("99*=");
    get_char(c);
    chk("rst_first", c, 8'h38);
    chk("rst_pre_stb", bus.out_stb, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_stb", bus.out_stb, 0);
    chk("rst_mid_char", bus.out_char, 0);
    chk("rst_mid_err", bus.err, 0);
    rst = 1'b0;
    run("post_rst", "9=", "9");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
